// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the data-memory port arbiter.
//   LOCK_CNT_W   : width of the per-tenure lock counter
//   ST_IDLE/LOCKED: raw state encodings, kept as plain constants for older code
//   arb_state_t  : arbiter state enum built on those encodings
//   next_idx()   : increment an index, wrapping modulo a count
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int LOCK_CNT_W = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = ST_IDLE,
        LOCKED = ST_LOCKED
    } arb_state_t;

    // Compare-and-reset rather than '%', so non-power-of-2 counts need no divider.
    function automatic int next_idx(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the requester handshakes and the shared memory port.
//   Handshake: a request is accepted on a rising edge where
//   req_valid[i] && req_ready[i]. req_ready never depends on anything but the
//   current inputs and arbiter state, and at most one bit is set. The owner of
//   an accepted transaction sees rsp_valid[i] for exactly one cycle afterwards.
//   master : requesters plus memory (drives req_*, mem_d_out)
//   slave  : the arbiter (drives req_ready, rsp_*, mem_read/write/addr/d_in)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int REQ_COUNT = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) ();

    logic [REQ_COUNT-1:0]             req_valid;
    logic [REQ_COUNT-1:0]             req_write;
    logic [REQ_COUNT-1:0]             req_lock;
    logic [REQ_COUNT-1:0][ADDR_W-1:0] req_addr;
    logic [REQ_COUNT-1:0][DATA_W-1:0] req_wdata;
    logic [REQ_COUNT-1:0]             req_ready;
    logic [REQ_COUNT-1:0]             rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;
    logic                             mem_read;
    logic                             mem_write;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_d_in;
    logic [DATA_W-1:0]                mem_d_out;

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata, mem_d_out,
        input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_d_in
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, mem_d_out,
        output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, mem_addr, mem_d_in
    );

endinterface

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational rotating priority encoder.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   gnt    : one-hot grant (zero when no request)
//   gnt_id : index of the granted bit (zero when no request)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_id
);

    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one data-memory port among REQ_COUNT requesters,
// with a bounded per-requester lock for atomic back-to-back sequences.
//   clk         : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   bus         : requester handshakes + memory port (slave view)
//   dbg_state_o : current arbiter state
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LOCK_MAX  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus,
    output arb_state_t    dbg_state_o
);

    localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam logic [LOCK_CNT_W-1:0] LOCK_LIM = LOCK_CNT_W'(LOCK_MAX);

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [LOCK_CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic                   rsp_pend_q, rsp_pend_d;
    logic [PTR_W-1:0]       rsp_id_q, rsp_id_d;
    logic                   rsp_wr_q, rsp_wr_d;

    logic [REQ_COUNT-1:0]   pick_gnt;
    logic [PTR_W-1:0]       pick_id;
    logic [REQ_COUNT-1:0]   owner_mask;
    logic [REQ_COUNT-1:0]   grant;
    logic                   accept;
    logic [PTR_W-1:0]       acc_id;
    logic [PTR_W-1:0]       acc_next;
    logic [LOCK_CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0]      addr_mux;
    logic [DATA_W-1:0]      data_mux;
    logic [REQ_COUNT-1:0]   rsp_vec;

    rr_picker #(.N(REQ_COUNT), .PTR_W(PTR_W)) u_picker (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    // While locked only the owner can be granted, even when it is idle.
    // Grant is held at zero during reset so nothing reaches memory.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        if (state_q == LOCKED) begin
            grant = owner_mask & bus.req_valid;
        end else begin
            grant = pick_gnt;
        end
        if (!reset_n) begin
            grant = '0;
        end
    end

    assign accept   = |(bus.req_valid & grant);
    assign acc_id   = (state_q == LOCKED) ? owner_q : pick_id;
    assign acc_next = PTR_W'(next_idx(int'(acc_id), REQ_COUNT));

    assign bus.req_ready = grant;
    assign bus.mem_read  = |(bus.req_valid & grant & ~bus.req_write);
    assign bus.mem_write = |(bus.req_valid & grant & bus.req_write);

    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (grant[i]) begin
                addr_mux = bus.req_addr[i];
                data_mux = bus.req_wdata[i];
            end
        end
    end

    assign bus.mem_addr = addr_mux;
    assign bus.mem_d_in = data_mux;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rsp_pend_d = accept;
        rsp_id_d   = rsp_id_q;
        rsp_wr_d   = rsp_wr_q;
        cnt_next   = '0;

        if (accept) begin
            rsp_id_d = acc_id;
            rsp_wr_d = bus.req_write[acc_id];
            if (bus.req_lock[acc_id]) begin
                if (state_q == IDLE) begin
                    cnt_next = LOCK_CNT_W'(1);
                end else if (lock_cnt_q >= LOCK_LIM) begin
                    cnt_next = lock_cnt_q;
                end else begin
                    cnt_next = lock_cnt_q + LOCK_CNT_W'(1);
                end
                // Reaching the bound ends the tenure so others cannot starve.
                if (cnt_next >= LOCK_LIM) begin
                    state_d    = IDLE;
                    rr_ptr_d   = acc_next;
                    lock_cnt_d = '0;
                end else begin
                    state_d    = LOCKED;
                    owner_d    = acc_id;
                    lock_cnt_d = cnt_next;
                end
            end else begin
                state_d    = IDLE;
                rr_ptr_d   = acc_next;
                lock_cnt_d = '0;
            end
        end else if (state_q == LOCKED && !bus.req_lock[owner_q] && !bus.req_valid[owner_q]) begin
            // In LOCKED acc_id is the owner, so acc_next is owner+1.
            state_d    = IDLE;
            rr_ptr_d   = acc_next;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= '0;
            rsp_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
            rsp_wr_q   <= rsp_wr_d;
        end
    end

    always_comb begin
        rsp_vec = '0;
        if (rsp_pend_q) begin
            rsp_vec[rsp_id_q] = 1'b1;
        end
    end

    assign bus.rsp_valid = rsp_vec;
    // Memory read data arrives the cycle after the read edge, aligned with rsp.
    assign bus.rsp_rdata = (rsp_pend_q && !rsp_wr_q) ? bus.mem_d_out : '0;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the CPU's single data-memory port (read/write/addr/d_in/d_out, including the memory-mapped I/O ports) among `REQ_COUNT` requesters, e.g. the CPU load/store path and a port-DMA engine. Each requester gets a valid/ready request handshake and a one-cycle response pulse. A per-requester lock lets a requester run an atomic sequence of back-to-back transactions. The lock is bounded by `LOCK_MAX` so other requesters cannot starve. The block sits between the requesters and `memory`, and drives that module's `read`, `write`, `addr` and `d_in` inputs.

## Interface
- `REQ_COUNT`, default 2: number of requesters, range 2..8.
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `LOCK_MAX`, default 4: maximum accepted transactions per lock tenure, range 1..15.
- `clk` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, [REQ_COUNT]: requester has a transaction presented.
- `req_write` input, [REQ_COUNT]: 1 = write, 0 = read.
- `req_lock` input, [REQ_COUNT]: hold the grant after this transaction.
- `req_addr` input, [REQ_COUNT][ADDR_W]: request address.
- `req_wdata` input, [REQ_COUNT][DATA_W]: request write data.
- `req_ready` output, [REQ_COUNT]: one-hot grant. A transaction is accepted when `valid && ready` at a rising edge.
- `rsp_valid` output, [REQ_COUNT]: one-cycle pulse to the owner of the completed transaction.
- `rsp_rdata` output, DATA_W: read data, shared by all requesters. It equals 0 for writes.
- `mem_read`, `mem_write` outputs, 1 bit each: connect to `memory`.
- `mem_addr` output, ADDR_W; `mem_d_in` output, DATA_W: connect to `memory`.
- `mem_d_out` input, DATA_W: `memory` read data, valid in the cycle after the read edge.

## Operation
- States:
  - IDLE: no owner. Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap-around.
  - LOCKED: grant is fixed to `owner`. No other requester is granted, even if the owner is idle.
- `req_ready`:
  - In IDLE, asserted only for the selected requester, and only while its `req_valid` is 1.
  - In LOCKED, asserted for `owner` whenever `owner` has `req_valid` set.
  - Never more than one bit set.
- Memory outputs:
  - `mem_read = |(req_valid & req_ready & ~req_write)`.
  - `mem_write = |(req_valid & req_ready & req_write)`.
  - `mem_addr` and `mem_d_in` mux from the granted requester. Both are 0 when nothing is granted.
- On acceptance by requester i:
  - `rsp_id` is set to i.
  - `rsp_pend` is set to 1.
  - `rsp_wr` is set to `req_write[i]`.
- Transition on acceptance with `req_lock[i]=1`, in IDLE or LOCKED:
  - Next state is LOCKED with `owner=i`.
  - `lock_cnt` increments. From IDLE it loads 1.
  - If the new `lock_cnt` reaches LOCK_MAX, the lock is force-released instead: next state is IDLE and `rr_ptr = (i+1) mod REQ_COUNT`.
- Transition on acceptance with `req_lock[i]=0`: next state is IDLE, `lock_cnt=0`, `rr_ptr=(i+1) mod REQ_COUNT`.
- LOCKED owner releases without a transaction: if the owner has `req_lock=0` and `req_valid=0` at an edge, next state is IDLE and `rr_ptr=owner+1`.
- No acceptance in IDLE: `rr_ptr` is unchanged.
- Arithmetic: `rr_ptr` and `owner` are `$clog2(REQ_COUNT)` bits wide, and their increments wrap modulo REQ_COUNT (also correct for non-power-of-2 counts). `lock_cnt` is 4 bits and saturates at LOCK_MAX.

## Timing
- Grant is combinational in the same cycle as the request, so there are no bubbles. With continuous traffic, one transaction is accepted every cycle.
- Response latency is 1 cycle. A transaction accepted at edge k raises `rsp_valid[rsp_id]` for the cycle after edge k.
  - Reads: `rsp_rdata = mem_d_out` in that cycle.
  - Writes: `rsp_rdata = 0` in that cycle.
- A response and a new acceptance may occur in the same cycle, for the same or different requesters.
- Reset values:
  - State IDLE; `rr_ptr=0`, `owner=0`, `lock_cnt=0`, `rsp_pend=0`.
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_d_in=0`.
  - `req_ready` and all `mem_*` outputs are forced to 0 while `reset_n=0`.
- Reset mid-operation: a pending response is discarded (no `rsp_valid` after reset deasserts) and any lock is dropped.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, LOCKED}.
  - A `LOCK_CNT_W=4` constant.
  - A `next_idx(idx, count)` wrap-increment function.
- Sub-module `rr_picker` is a purely combinational rotating priority encoder: inputs `req`, `ptr`; outputs one-hot `gnt` and index `gnt_id`.
- The top level holds the state register, counters, response pipeline register and memory-port mux.

## Test plan
- Single read: req0 reads addr 0x0010, which holds 0xBEEF → `req_ready[0]` same cycle, `mem_read=1`, `rsp_valid[0]` one cycle later, `rsp_rdata=0xBEEF`.
- Contention: both requesters valid continuously, no lock → grants alternate 0,1,0,1. `rr_ptr` after reset selects req0 first.
- Lock: req1 locked for 3 writes while req0 waits → req0 is granted only after req1's third transaction, when req1 drops `req_lock`.
- Lock bound: req0 holds `req_lock=1` continuously with LOCK_MAX=4 and req1 waiting → exactly 4 accepts for req0, then req1 is granted.
- Back-to-back: write 0x1234 to 0x20, then read 0x20 on the next cycle → read response is 0x1234. `rsp_valid` is asserted on consecutive cycles.
- Reset mid-read: `reset_n` pulsed low in the cycle after acceptance → no `rsp_valid`, all outputs 0, and the first grant after reset goes to req0.
